// File: rtl/fourier_readout.sv
// Result buffer for the Fourier datapath: stores one frame of DEPTH bins from
// the transform core, then answers registered regAddr -> regData reads while done is high.
module fourier_readout #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [31:0]       regAddr,
  output logic [31:0]       regData,
  output logic              done,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  state_t            state;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_accept;
  logic              unused_addr;

  // Handshake: a bin transfers on any edge where wr_valid && wr_ready, unless
  // start is high in that cycle, in which case the new frame wins and the bin is dropped.
  assign wr_accept   = wr_valid && wr_ready && (state == COLLECT) && !start;
  assign rd_idx      = regAddr[AW-1:0];
  assign unused_addr = ^regAddr[31:AW];

  // Result storage carries no reset; done gates every read of it.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= COLLECT;
      wr_idx   <= '0;
      wr_ready <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else if (start) begin
      state    <= COLLECT;
      wr_idx   <= '0;
      wr_ready <= 1'b1;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          wr_ready <= 1'b1;
          done     <= 1'b0;
          if (wr_accept) begin
            if (wr_idx == AW'(DEPTH - 1)) begin
              state    <= DONE;
              wr_idx   <= '0;
              wr_ready <= 1'b0;
              done     <= 1'b1;
            end else begin
              wr_idx <= wr_idx + AW'(1);
            end
          end
        end
        DONE: begin
          wr_ready <= 1'b0;
          done     <= 1'b1;
          if (wr_valid) overflow <= 1'b1;
        end
        default: begin
          state    <= COLLECT;
          wr_idx   <= '0;
          wr_ready <= 1'b1;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // Read uses the registered done, so a start pulse in DONE still returns stored data that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) regData <= '0;
    else       regData <= done ? 32'(mem[rd_idx]) : 32'd0;
  end

endmodule

// File: tb/tb_fourier_readout.sv
// Directed bench for fourier_readout: frame capture, wrapped reads, gaps,
// overflow, start/write collision and asynchronous reset.
module tb_fourier_readout;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              start;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [31:0]       regAddr;
  logic [31:0]       regData;
  logic              done;
  logic              overflow;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  fourier_readout #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .regAddr  (regAddr),
    .regData  (regData),
    .done     (done),
    .overflow (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_bin(input logic [31:0] data, input logic exp_done, input string tag);
    wr_valid = 1'b1;
    wr_data  = data;
    step();
    wr_valid = 1'b0;
    check(tag, {31'd0, done}, {31'd0, exp_done});
  endtask

  task automatic read_bin(input int addr, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    regAddr = addr;
    exp_q.push_back(exp);
    step();
    e = exp_q.pop_front();
    check(tag, regData, e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int k;
    int c;
    logic v;
    reset    = 1'b1;
    start    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    regAddr  = '0;

    #1;
    check("rst_regdata", regData, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    check("post_rst_wr_ready", {31'd0, wr_ready}, 32'd1);

    // frame 1: back-to-back writes
    for (int i = 0; i < DEPTH; i++) write_bin(32'h100 + i, i == DEPTH - 1, "f1_done");
    check("f1_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("f1_overflow", {31'd0, overflow}, 32'd0);

    // stepped reads including wrap past DEPTH
    for (int a = 0; a <= 20; a++) read_bin(a, 32'h100 + (a % DEPTH), "f1_read");

    // overflow in DONE
    wr_valid = 1'b1;
    wr_data  = 32'hDEAD;
    step();
    wr_valid = 1'b0;
    check("ovf_set", {31'd0, overflow}, 32'd1);
    step();
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    read_bin(0, 32'h100, "ovf_bin0");

    // start in DONE: the same-cycle read still returns stored data
    regAddr = 5;
    exp_q.push_back(32'h105);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_read", regData, exp_q.pop_front());
    check("start_ovf", {31'd0, overflow}, 32'd0);
    check("start_done", {31'd0, done}, 32'd0);
    check("start_wr_ready", {31'd0, wr_ready}, 32'd1);
    step();
    check("collect_rdata_zero", regData, 32'd0);

    // writes with gaps
    k = 0;
    c = 0;
    while (k < DEPTH && c < 400) begin
      v = (c % 3 == 0) || ($urandom_range(0, 3) == 0);
      wr_valid = v;
      wr_data  = v ? 32'h300 + k : 32'hBAD;
      regAddr  = $urandom_range(0, 31);
      step();
      if (v) k++;
      check("gap_done", {31'd0, done}, {31'd0, k == DEPTH});
      if (k < DEPTH) check("gap_rdata_zero", regData, 32'd0);
      c++;
    end
    wr_valid = 1'b0;
    check("gap_count", k, DEPTH);
    for (int a = 0; a < DEPTH; a++) read_bin(a, 32'h300 + a, "gap_read");

    // start coincident with write 7
    pulse_start();
    for (int i = 0; i < 7; i++) write_bin(32'h400 + i, 1'b0, "coll_pre_done");
    start    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 32'h4FF;
    step();
    start    = 1'b0;
    wr_valid = 1'b0;
    check("coll_done", {31'd0, done}, 32'd0);
    check("coll_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("coll_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < DEPTH; i++) write_bin(32'h200 + i, i == DEPTH - 1, "coll_done_seq");
    for (int a = 0; a < DEPTH; a++) read_bin(a, 32'h200 + a, "coll_read");

    // asynchronous reset mid-frame
    pulse_start();
    for (int i = 0; i < 9; i++) write_bin(32'h600 + i, 1'b0, "rst_frame_done");
    #2;
    reset = 1'b1;
    #1;
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_regdata", regData, 32'd0);
    check("arst_wr_ready", {31'd0, wr_ready}, 32'd0);
    step();
    reset = 1'b0;
    step();
    check("arst_rel_wr_ready", {31'd0, wr_ready}, 32'd1);
    for (int i = 0; i < DEPTH; i++) write_bin(32'h500 + i, i == DEPTH - 1, "arst_refill_done");
    for (int a = 0; a < DEPTH; a++) read_bin(a + DEPTH, 32'h500 + a, "arst_wrap_read");

    // asynchronous reset while DONE clears live read data
    read_bin(3, 32'h503, "arst2_pre");
    #2;
    reset = 1'b1;
    #1;
    check("arst2_regdata", regData, 32'd0);
    check("arst2_done", {31'd0, done}, 32'd0);
    step();
    reset = 1'b0;
    step();

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
